// File: rtl/pipeline_pkg.sv
// Shared write-back types and RF write-enable encodings.
// Used by the write-port arbiter and its pending-write scoreboard.
package pipeline_pkg;

   localparam logic [1:0] WE_IDLE = 2'b00;
   localparam logic [1:0] WE_NORM = 2'b01;
   localparam logic [1:0] WE_LINK = 2'b11;

   localparam int unsigned RF_AW   = 5;
   localparam int unsigned RF_DW   = 32;
   localparam int unsigned RF_NREG = 32;

   localparam logic [RF_AW-1:0] LINK_REG = 5'd1;

   typedef struct packed {
      logic [RF_AW-1:0] addr;
      logic [RF_DW-1:0] data;
      logic             link;
   } wb_req_t;

   // A plain write to r0 is accepted but produces no RF write.
   function automatic logic [1:0] we_encode(input logic link, input logic [RF_AW-1:0] addr);
      if (link) return WE_LINK;
      if (addr != '0) return WE_NORM;
      return WE_IDLE;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register 2-bit saturating pending-write counters (r1..r31).
// Issue increments, committed RF writes decrement; exports pend_mask and iss_ready.
module rf_scoreboard
   import pipeline_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               iss_valid_i,
   input  logic [RF_AW-1:0]   iss_addr_i,
   input  logic               iss_link_i,
   output logic               iss_ready_o,
   input  logic [1:0]         dec_we_i,
   input  logic [RF_AW-1:0]   dec_addr_i,
   output logic [RF_NREG-1:0] pend_mask_o
);

   logic [1:0]         cnt_q [RF_NREG];
   logic [1:0]         cnt_d [RF_NREG];
   logic [RF_NREG-1:0] inc;
   logic [RF_NREG-1:0] dec;
   logic               iss_fire;

   always_comb begin
      iss_ready_o = !rst_i
                    && !((iss_addr_i != '0) && (cnt_q[iss_addr_i] == 2'd3))
                    && !(iss_link_i && (cnt_q[LINK_REG] == 2'd3));
      iss_fire = iss_valid_i && iss_ready_o;

      // Set-style masks: addr==r1 together with link counts only once.
      inc = '0;
      if (iss_fire) begin
         if (iss_addr_i != '0) inc[iss_addr_i] = 1'b1;
         if (iss_link_i) inc[LINK_REG] = 1'b1;
      end
      dec = '0;
      if (dec_we_i != WE_IDLE) begin
         if (dec_addr_i != '0) dec[dec_addr_i] = 1'b1;
         if (dec_we_i == WE_LINK) dec[LINK_REG] = 1'b1;
      end
   end

   always_comb begin
      cnt_d    = cnt_q;
      cnt_d[0] = '0;
      for (int r = 1; r < RF_NREG; r++) begin
         if (inc[r] && !dec[r] && (cnt_q[r] != 2'd3)) begin
            cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (dec[r] && !inc[r] && (cnt_q[r] != 2'd0)) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
   end

   always_comb begin
      pend_mask_o = '0;
      for (int r = 1; r < RF_NREG; r++) begin
         pend_mask_o[r] = (cnt_q[r] != 2'd0);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < RF_NREG; r++) cnt_q[r] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         assert ((dec & ~pend_mask_o) == '0)
         else $error("rf_scoreboard: write retired for a register with no pending issue");
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Round-robin owner of the RF write port with a registered write stage.
// DW/AW track the package widths; the scoreboard covers all 32 registers.
module rf_wb_arbiter
   import pipeline_pkg::*;
#(
   parameter int unsigned N  = 3,
   parameter int unsigned DW = RF_DW,
   parameter int unsigned AW = RF_AW
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N-1:0]    req_valid_i,
   input  logic [N*AW-1:0] req_addr_i,
   input  logic [N*DW-1:0] req_data_i,
   input  logic [N-1:0]    req_link_i,
   output logic [N-1:0]    req_ready_o,
   output logic [1:0]      rf_we_o,
   output logic [AW-1:0]   rf_wr_o,
   output logic [DW-1:0]   rf_wd_o,
   input  logic            iss_valid_i,
   input  logic [AW-1:0]   iss_addr_i,
   input  logic            iss_link_i,
   output logic            iss_ready_o,
   output logic [31:0]     pend_mask_o
);

   localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] rr_q, rr_d;
   logic [PW-1:0] gnt_idx;
   logic          found;
   logic          xfer;
   logic [1:0]    we_q, we_d;
   wb_req_t       wb_q, wb_d;
   wb_req_t       sel;
   int unsigned   j;

   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      j       = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(rr_q) + k) % N;
         if (!found && req_valid_i[PW'(j)]) begin
            found   = 1'b1;
            gnt_idx = PW'(j);
         end
      end
      xfer        = found && !rst_i;
      req_ready_o = '0;
      if (xfer) req_ready_o[gnt_idx] = 1'b1;
   end

   always_comb begin
      sel.addr = req_addr_i[gnt_idx*AW +: AW];
      sel.data = req_data_i[gnt_idx*DW +: DW];
      sel.link = req_link_i[gnt_idx];

      rr_d = rr_q;
      we_d = WE_IDLE;
      wb_d = wb_q;
      if (xfer) begin
         rr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
         we_d = we_encode(sel.link, sel.addr);
         wb_d = sel;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_q <= '0;
         we_q <= WE_IDLE;
         wb_q <= '0;
      end else begin
         rr_q <= rr_d;
         we_q <= we_d;
         wb_q <= wb_d;
      end
   end

   // A write still held in the stage when reset rises must never reach the RF.
   assign rf_we_o = rst_i ? WE_IDLE : we_q;
   assign rf_wr_o = wb_q.addr;
   assign rf_wd_o = wb_q.data;

   rf_scoreboard u_scoreboard (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .iss_valid_i (iss_valid_i),
      .iss_addr_i  (iss_addr_i),
      .iss_link_i  (iss_link_i),
      .iss_ready_o (iss_ready_o),
      .dec_we_i    (rf_we_o),
      .dec_addr_i  (wb_q.addr),
      .pend_mask_o (pend_mask_o)
   );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: arbitration table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_rf_wb_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*5-1:0]  req_addr;
   logic [N*32-1:0] req_data;
   logic [N-1:0]  req_link;
   logic [N-1:0]  req_ready;
   logic [1:0]    rf_we;
   logic [4:0]    rf_wr;
   logic [31:0]   rf_wd;
   logic          iss_valid;
   logic [4:0]    iss_addr;
   logic          iss_link;
   logic          iss_ready;
   logic [31:0]   pend_mask;

   rf_wb_arbiter #(.N(N), .DW(32), .AW(5)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_link_i  (req_link),
      .req_ready_o (req_ready),
      .rf_we_o     (rf_we),
      .rf_wr_o     (rf_wr),
      .rf_wd_o     (rf_wd),
      .iss_valid_i (iss_valid),
      .iss_addr_i  (iss_addr),
      .iss_link_i  (iss_link),
      .iss_ready_o (iss_ready),
      .pend_mask_o (pend_mask)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: pending counts per register, pointer, registered write.
   int         m_ptr;
   int         m_cnt [32];
   logic [1:0] m_we;
   logic [4:0] m_wr;
   logic [31:0] m_wd;
   int         last_grant;
   logic       last_fire;

   typedef struct { logic [4:0] addr; logic link; } job_t;
   job_t jobs[$];

   typedef struct { logic [N-1:0] valid; logic [N-1:0] ready; } arb_vec_t;
   arb_vec_t tbl [10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0;
      m_we  = 2'b00;
      m_wr  = '0;
      m_wd  = '0;
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
   endtask

   // Check at the falling edge, then advance model and DUT one rising edge.
   task automatic step();
      int g;
      logic [N-1:0] e_rdy;
      logic e_iss;
      logic [31:0] e_mask;
      bit incb [32];
      bit decb [32];
      @(negedge clk);
      g = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         end
      end
      e_rdy = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      e_iss = !rst && !(iss_addr != 0 && m_cnt[iss_addr] == 3) && !(iss_link && m_cnt[1] == 3);
      e_mask = '0;
      for (int r = 1; r < 32; r++) e_mask[r] = (m_cnt[r] > 0);
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("iss_ready", 32'(iss_ready), 32'(e_iss));
      chk("rf_we", 32'(rf_we), rst ? 32'd0 : 32'(m_we));
      chk("rf_wr", 32'(rf_wr), 32'(m_wr));
      chk("rf_wd", rf_wd, m_wd);
      chk("pend_mask", pend_mask, e_mask);
      last_grant = g;
      last_fire  = iss_valid && e_iss;
      if (rst) begin
         model_reset();
      end else begin
         for (int r = 0; r < 32; r++) begin incb[r] = 0; decb[r] = 0; end
         if (last_fire) begin
            if (iss_addr != 0) incb[iss_addr] = 1;
            if (iss_link) incb[1] = 1;
         end
         if (m_we != 2'b00) begin
            if (m_wr != 0) decb[m_wr] = 1;
            if (m_we == 2'b11) decb[1] = 1;
         end
         for (int r = 1; r < 32; r++) begin
            m_cnt[r] = m_cnt[r] + int'(incb[r]) - int'(decb[r]);
            if (m_cnt[r] > 3) m_cnt[r] = 3;
            if (m_cnt[r] < 0) m_cnt[r] = 0;
         end
         if (g >= 0) begin
            m_ptr = (g + 1) % N;
            m_wr  = req_addr[g*5 +: 5];
            m_wd  = req_data[g*32 +: 32];
            if (req_link[g]) m_we = 2'b11;
            else if (req_addr[g*5 +: 5] != 0) m_we = 2'b01;
            else m_we = 2'b00;
         end else begin
            m_we = 2'b00;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d, input logic l);
      req_valid[i] = 1'b1;
      req_addr[i*5 +: 5]   = a;
      req_data[i*32 +: 32] = d;
      req_link[i] = l;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_link  = '0;
   endtask

   task automatic do_issue(input logic [4:0] a, input logic l);
      iss_valid = 1'b1;
      iss_addr  = a;
      iss_link  = l;
      step();
      iss_valid = 1'b0;
      iss_link  = 1'b0;
   endtask

   initial begin
      logic [31:0] mask_save;
      tbl[0] = '{3'b111, 3'b001};
      tbl[1] = '{3'b111, 3'b010};
      tbl[2] = '{3'b111, 3'b100};
      tbl[3] = '{3'b110, 3'b010};
      tbl[4] = '{3'b011, 3'b001};
      tbl[5] = '{3'b100, 3'b100};
      tbl[6] = '{3'b000, 3'b000};
      tbl[7] = '{3'b010, 3'b010};
      tbl[8] = '{3'b001, 3'b001};
      tbl[9] = '{3'b101, 3'b100};

      rst = 1'b1;
      req_valid = '1;
      req_addr = '0;
      req_data = '0;
      req_link = '0;
      iss_valid = 1'b0;
      iss_addr = '0;
      iss_link = 1'b0;
      @(posedge clk);
      #1;
      model_reset();

      // Reset held with every requester valid.
      iss_valid = 1'b1;
      iss_addr  = 5'd3;
      step();
      step();
      iss_valid = 1'b0;
      rst = 1'b0;

      // Arbitration table with dropped r0 writes (no scoreboard effect).
      for (int i = 0; i < 10; i++) begin
         req_valid = tbl[i].valid;
         req_addr  = '0;
         req_link  = '0;
         req_data  = {$urandom, $urandom, $urandom};
         #2;
         chk("tbl_ready", 32'(req_ready), 32'(tbl[i].ready));
         step();
      end
      clear_reqs();
      step();

      // Round robin over r5/r6/r7, two writes each.
      for (int k = 0; k < 2; k++) begin
         do_issue(5'd5, 1'b0);
         do_issue(5'd6, 1'b0);
         do_issue(5'd7, 1'b0);
      end
      set_req(0, 5'd5, 32'h0000_0005, 1'b0);
      set_req(1, 5'd6, 32'h0000_0006, 1'b0);
      set_req(2, 5'd7, 32'h0000_0007, 1'b0);
      for (int k = 0; k < 6; k++) step();
      clear_reqs();
      step();
      step();
      chk("rr_drained", 32'(pend_mask[7:5]), 32'd0);

      // Link write to r31 from requester 1.
      do_issue(5'd31, 1'b1);
      set_req(1, 5'd31, 32'hDEAD_BEEF, 1'b1);
      step();
      clear_reqs();
      #2;
      chk("link_we", 32'(rf_we), 32'h3);
      chk("link_wd", rf_wd, 32'hDEAD_BEEF);
      step();
      step();
      chk("link_r1_r31", {30'd0, pend_mask[31], pend_mask[1]}, 32'd0);

      // Dropped write to r0.
      mask_save = pend_mask;
      set_req(0, 5'd0, 32'h0000_1234, 1'b0);
      step();
      clear_reqs();
      step();
      chk("r0_mask", pend_mask, mask_save);

      // Saturation on r4 with a write overlapping a stalled issue.
      do_issue(5'd4, 1'b0);
      do_issue(5'd4, 1'b0);
      do_issue(5'd4, 1'b0);
      iss_valid = 1'b1;
      iss_addr  = 5'd4;
      #2;
      chk("sat_stall", 32'(iss_ready), 32'd0);
      set_req(0, 5'd4, 32'h4444_0000, 1'b0);
      step();
      clear_reqs();
      step();
      step();
      iss_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         set_req(0, 5'd4, 32'h4444_0001 + k, 1'b0);
         step();
         clear_reqs();
         step();
      end
      step();
      chk("sat_drained", 32'(pend_mask[4]), 32'd0);

      // Randomized traffic; every real write retires an earlier issue.
      for (int c = 0; c < 1500; c++) begin
         if (last_fire) jobs.push_back('{iss_addr, iss_link});
         if (last_grant >= 0) req_valid[last_grant] = 1'b0;
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i]) begin
               int r;
               r = $urandom_range(0, 3);
               if (r == 0 && jobs.size() > 0) begin
                  int idx;
                  idx = $urandom_range(0, jobs.size() - 1);
                  set_req(i, jobs[idx].addr, $urandom, jobs[idx].link);
                  jobs.delete(idx);
               end else if (r == 1) begin
                  set_req(i, 5'd0, $urandom, 1'b0);
               end
            end
         end
         iss_valid = 1'($urandom_range(0, 1));
         iss_addr  = 5'($urandom_range(0, 7));
         iss_link  = ($urandom_range(0, 4) == 0);
         step();
      end
      clear_reqs();
      iss_valid = 1'b0;
      iss_link  = 1'b0;
      step();
      step();

      // Reset arriving one cycle after a transfer discards the write.
      do_issue(5'd9, 1'b0);
      set_req(0, 5'd9, 32'h9999_9999, 1'b0);
      step();
      clear_reqs();
      rst = 1'b1;
      #2;
      chk("midrst_we", 32'(rf_we), 32'd0);
      step();
      step();
      rst = 1'b0;
      step();
      chk("midrst_mask", pend_mask, 32'd0);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sole owner of the register-file write port.
- Shares the port between N write-back producers (ALU pipe, multi-cycle mul/div, load unit) using round-robin arbitration with valid/ready handshakes.
- Drives the RF write controls (we[1:0], wR, wD) from a registered output stage.
- Keeps a per-register pending-write scoreboard so decode can stall on RAW hazards against in-flight producers.

Parameters:
- N, 3, number of write-back requesters (2..4)
- DW, 32, data width
- AW, 5, register address width (32 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  requester i holds a write
- req_addr  in  N*AW  destination register, slice i
- req_data  in  N*DW  write data, slice i
- req_link  in  N  link write: also write DW data to r1
- req_ready  out  N  grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- rf_we  out  2  to RF we: 00 idle, 01 normal write, 11 normal write plus r1 link write; 10 never driven
- rf_wR  out  AW  to RF wR
- rf_wD  out  DW  to RF wD
- iss_valid  in  1  decode issues an instruction that will write back
- iss_addr  in  AW  its destination register
- iss_link  in  1  issued instruction also writes r1
- iss_ready  out  1  low means the scoreboard is saturated for iss_addr (or r1 if iss_link); decode must stall
- pend_mask  out  32  bit r = 1 while register r has an outstanding write; bit 0 always 0

Behaviour:
- Reset (rst=1 at an edge): rf_we=00, rf_wR=0, rf_wD=0, rr_ptr=0, all scoreboard counters=0. While rst is high, req_ready=0 and iss_ready=0.
- Arbitration (combinational, per cycle): search from rr_ptr upward, modulo N. The first i with req_valid[i] gets req_ready[i]=1; all other ready bits are 0. At most one grant per cycle.
- Ready depends only on rr_ptr and req_valid.
- After a transfer from i, rr_ptr <= (i+1) mod N. With no transfer, rr_ptr holds.
- Output stage, 1-cycle latency. A transfer in cycle t registers rf_wR/rf_wD and sets rf_we in cycle t+1. The RF commits at the end of t+1.
- With no transfer, rf_we <= 00; rf_wR/rf_wD hold their last values.
- rf_we encoding: req_link=1 gives 11. req_link=0 with addr≠0 gives 01. req_link=0 with addr=0 is accepted and dropped, giving 00.
- Scoreboard: one 2-bit saturating counter per register r=1..31. r0 is never tracked.
- Increment: iss_valid and iss_ready increment cnt[iss_addr] (if addr≠0), and cnt[1] if iss_link.
- Decrement: a registered output with rf_we≠00 decrements cnt[rf_wR] (if ≠0), and cnt[1] if rf_we=11. Decrement happens in the same cycle the RF commits.
- Increment and decrement on the same register in the same cycle leave the count unchanged.
- If iss_addr=1 and iss_link=1, the issue counts once for r1. The same rule applies to rf_wR=1 with rf_we=11.
- iss_ready=0 when the target counter (or cnt[1] with iss_link) is 3. A saturated counter never wraps.
- A decrement at count 0 is a protocol violation: the counter stays 0 and a simulation assertion fires.
- pend_mask[r] = (cnt[r]≠0), decoded from registered state. No same-cycle bypass; decode sees a clear only after the RF write has committed.
- Any in-flight registered write present when rst rises is discarded: rf_we is forced to 00.

Decomposition:
- Shared package pipeline_pkg holds:
  - WE_IDLE=2'b00, WE_NORM=2'b01, WE_LINK=2'b11
  - LINK_REG=5'd1
  - RF_AW=5, RF_DW=32
  - typedef wb_req_t {addr, data, link}
- One natural sub-module, rf_scoreboard: 31 counters plus the inc/dec/saturation logic. It exports pend_mask and iss_ready.
- Arbiter and output register stay in the top level.

Test Plan:
- Reset: assert rst 2 cycles with all req_valid=1 -> req_ready=000, rf_we=00, pend_mask=0; first post-reset grant goes to requester 0.
- Round-robin: req_valid=111 held 6 cycles with addrs 5/6/7 -> grants 0,1,2,0,1,2; rf_wR=5,6,7,... one cycle later with rf_we=01.
- Link: requester 1 valid, addr=31, data=0xDEADBEEF, link=1 -> next cycle rf_we=11, rf_wR=31, rf_wD=0xDEADBEEF; r1 and r31 counters both decrement.
- r0 drop: addr=0, link=0, data=0x1234 -> req_ready=1, next cycle rf_we=00; pend_mask unchanged.
- Scoreboard saturation: issue addr=4 three times -> pend_mask[4]=1, iss_ready=0 on the 4th issue. A write to r4 combined with a same-cycle issue to r4 -> count stays 3. Three more writes -> pend_mask[4]=0.
- Mid-op reset: transfer in cycle t, rst=1 in t+1 -> rf_we=00 in t+1 and after; all counters 0.
